// File: rtl/mem_test_pkg.sv
// ----------------------------------------------------------------------------
// mem_test_pkg
// Shared types and constants for the memory test sequencer:
//   state_t      FSM states (IDLE, DELAY, ISSUE, WAIT, DONE)
//   PH_WRITE/PH_READ   phase encoding
//   RWB_WRITE/RWB_READ ReqRWB encoding
//   PATTERN_XOR  constant XORed into the address byte to form test data
//   pattern_byte helper producing the 8-bit data pattern for an address byte
// ----------------------------------------------------------------------------
package mem_test_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic PH_WRITE  = 1'b0;
    localparam logic PH_READ   = 1'b1;

    localparam logic RWB_WRITE = 1'b0;
    localparam logic RWB_READ  = 1'b1;

    localparam logic [7:0] PATTERN_XOR = 8'hA5;

    function automatic logic [7:0] pattern_byte(input logic [7:0] addr_byte);
        return addr_byte ^ PATTERN_XOR;
    endfunction

endpackage

// File: rtl/mem_test_addr_gen.sv
// ----------------------------------------------------------------------------
// mem_test_addr_gen
// Holds the transaction index and maps it to a request address and the
// patterned data word for that address.
//   Clk, ResetN  clock, asynchronous active-low reset
//   clear        force index to 0 (held while the sequencer is idle)
//   advance      step to the next index; wraps to 0 after the last one
//   addr         address for the current index (sequential or strided)
//   data         pattern byte for addr, replicated across DATA_W
//   last         current index is NUM_REQ-1
// ----------------------------------------------------------------------------
module mem_test_addr_gen
    import mem_test_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8,
    parameter int NUM_REQ = 16,
    parameter int MODE    = 0,
    parameter int STRIDE  = 5
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              clear,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              last
);

    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_REQ - 1);
    localparam logic [ADDR_W-1:0] STRIDE_W = ADDR_W'(STRIDE);
    localparam int                REP      = (DATA_W + 7) / 8;

    logic [ADDR_W-1:0] idx;
    logic [7:0]        addr_byte;
    logic [REP*8-1:0]  data_rep;

    // NOTE: the index is plain control state, so it sits on the async reset
    // like every other register here; nothing in this block is a memory array.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (advance) begin
            idx <= last ? '0 : idx + 1'b1;
        end
    end

    assign last = (idx == IDX_LAST);

    // The product is truncated to ADDR_W bits, which is exactly the
    // "mod 2**ADDR_W" wrap of the strided pattern.
    generate
        if (MODE == 1) begin : g_strided
            assign addr = idx * STRIDE_W;
        end else begin : g_sequential
            assign addr = idx;
        end
    endgenerate

    // Address is zero-extended or truncated to one byte before the XOR,
    // then the byte is tiled across the data word.
    assign addr_byte = 8'(addr);
    assign data_rep  = {REP{pattern_byte(addr_byte)}};
    assign data      = data_rep[DATA_W-1:0];

endmodule

// File: rtl/mem_test_sequencer.sv
// ----------------------------------------------------------------------------
// mem_test_sequencer
// Processor-side traffic sequencer for the cache memory system. After a run
// is started (Enable high in IDLE) and START_DELAY cycles have elapsed it
// writes NUM_REQ patterned words, reads them back, and counts mismatches.
// One request is outstanding at a time.
//
// Optional feature: define MEM_TEST_HIT_STATS_EN to add HitCount/MissCount
// outputs (16-bit saturating, cleared on run start). Without it RspHit is
// ignored.
//
// Ports:
//   Clk, ResetN     clock, asynchronous active-low reset
//   Enable          level; starts a run from IDLE, dropping it ends the run
//                   after the current request completes
//   ReqValid/Ready  request handshake, ReqRWB 1=read 0=write
//   ReqAddr/WData   request address and write data (held until accepted)
//   RspValid        one-cycle response strobe per accepted request
//   RspHit          cache hit flag with RspValid
//   RspRData        read data with RspValid
//   Busy            high in DELAY/ISSUE/WAIT
//   Done            high in DONE
//   ErrCount        read-back mismatches, saturating at 255
// ----------------------------------------------------------------------------
module mem_test_sequencer
    import mem_test_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int DATA_W      = 8,
    parameter int NUM_REQ     = 16,
    parameter int START_DELAY = 3,
    parameter int MODE        = 0,
    parameter int STRIDE      = 5
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              Enable,
    output logic              ReqValid,
    input  logic              ReqReady,
    output logic              ReqRWB,
    output logic [ADDR_W-1:0] ReqAddr,
    output logic [DATA_W-1:0] ReqWData,
    input  logic              RspValid,
    input  logic              RspHit,
    input  logic [DATA_W-1:0] RspRData,
    output logic              Busy,
    output logic              Done,
`ifdef MEM_TEST_HIT_STATS_EN
    output logic [15:0]       HitCount,
    output logic [15:0]       MissCount,
`endif
    output logic [7:0]        ErrCount
);

    localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

    state_t            state;
    logic              phase;
    logic              was_last;
    logic [DLY_W-1:0]  dly_cnt;

    logic              gen_clear;
    logic              gen_advance;
    logic [ADDR_W-1:0] gen_addr;
    logic [DATA_W-1:0] gen_data;
    logic              gen_last;

    // The index advances at the handshake, so while waiting for the
    // response the generator already presents the next request.
    assign gen_clear   = (state == IDLE);
    assign gen_advance = (state == ISSUE) && ReqReady;

    mem_test_addr_gen #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NUM_REQ (NUM_REQ),
        .MODE    (MODE),
        .STRIDE  (STRIDE)
    ) u_addr_gen (
        .Clk     (Clk),
        .ResetN  (ResetN),
        .clear   (gen_clear),
        .advance (gen_advance),
        .addr    (gen_addr),
        .data    (gen_data),
        .last    (gen_last)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // branch below reads the pre-edge values of state, phase and counters.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state    <= IDLE;
            phase    <= PH_WRITE;
            was_last <= 1'b0;
            dly_cnt  <= '0;
            ReqValid <= 1'b0;
            ReqRWB   <= RWB_WRITE;
            ReqAddr  <= '0;
            ReqWData <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            ErrCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Enable) begin
                        ErrCount <= '0;
                        phase    <= PH_WRITE;
                        Busy     <= 1'b1;
                        Done     <= 1'b0;
                        if (START_DELAY == 0) begin
                            state    <= ISSUE;
                            ReqValid <= 1'b1;
                            ReqRWB   <= RWB_WRITE;
                            ReqAddr  <= gen_addr;
                            ReqWData <= gen_data;
                        end else begin
                            state   <= DELAY;
                            dly_cnt <= DLY_W'(START_DELAY - 1);
                        end
                    end
                end

                DELAY: begin
                    if (!Enable) begin
                        // Nothing issued yet, so the run can stop at once.
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end else if (dly_cnt == '0) begin
                        state    <= ISSUE;
                        ReqValid <= 1'b1;
                        ReqRWB   <= RWB_WRITE;
                        ReqAddr  <= gen_addr;
                        ReqWData <= gen_data;
                    end else begin
                        dly_cnt <= dly_cnt - 1'b1;
                    end
                end

                ISSUE: begin
                    // Enable is ignored here: an offered request is always
                    // carried through to its response.
                    if (ReqReady) begin
                        ReqValid <= 1'b0;
                        was_last <= gen_last;
                        state    <= WAIT;
                    end
                end

                WAIT: begin
                    if (RspValid) begin
                        // ReqWData still holds the pattern of the request
                        // being answered, so it doubles as the expected data.
                        if ((phase == PH_READ) && (RspRData != ReqWData) &&
                            (ErrCount != 8'hFF)) begin
                            ErrCount <= ErrCount + 8'd1;
                        end
                        if (!Enable) begin
                            state <= IDLE;
                            Busy  <= 1'b0;
                        end else if (!was_last) begin
                            state    <= ISSUE;
                            ReqValid <= 1'b1;
                            ReqRWB   <= (phase == PH_READ) ? RWB_READ : RWB_WRITE;
                            ReqAddr  <= gen_addr;
                            ReqWData <= gen_data;
                        end else if (phase == PH_WRITE) begin
                            phase    <= PH_READ;
                            state    <= ISSUE;
                            ReqValid <= 1'b1;
                            ReqRWB   <= RWB_READ;
                            ReqAddr  <= gen_addr;
                            ReqWData <= gen_data;
                        end else begin
                            state <= DONE;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    if (!Enable) begin
                        state <= IDLE;
                        Done  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_TEST_HIT_STATS_EN
    logic run_start;
    logic rsp_seen;

    assign run_start = (state == IDLE) && Enable;
    assign rsp_seen  = (state == WAIT) && RspValid;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            HitCount  <= '0;
            MissCount <= '0;
        end else if (run_start) begin
            HitCount  <= '0;
            MissCount <= '0;
        end else if (rsp_seen) begin
            if (RspHit) begin
                if (HitCount != 16'hFFFF) HitCount <= HitCount + 16'd1;
            end else begin
                if (MissCount != 16'hFFFF) MissCount <= MissCount + 16'd1;
            end
        end
    end
`else
    logic unused_rsp_hit;
    assign unused_rsp_hit = RspHit;
`endif

endmodule
